uart_transmisor: RTL
====================

// Module: uart_transmisor
// PURPOSE
//  UART transmit end of the serial link whose receive end feeds the hand-position path.
//  Serialises bytes, e.g. the basket's current x position, back to the host PC as 8-N-1 by default.
//  Has a one-byte holding register so the next byte is accepted while the current frame shifts.
//  Sits beside the UART receiver in the game top; tx goes straight to the board's serial TX pin.
// PARAMETERS
//  CLK_FREQ      50_000_000  system clock frequency, Hz
//  BAUD          9600        line rate, bit/s
//  CLKS_PER_BIT  CLK_FREQ/BAUD (5208)  cycles per bit; overridable (16 in simulation)
//  PARITY        0           0 none, 1 even, 2 odd
//  STOP_BITS     1           1 or 2
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-low; async assert, sync deassert at top level
//  tx_start  in   1  request: tx_byte is valid this cycle
//  tx_byte   in   8  byte to send; bit 0 goes on the line first (LSB first)
//  tx_ready  out  1  holding register empty; a tx_start is accepted only while high
//  busy      out  1  frame in progress OR holding register full
//  tx_done   out  1  one-cycle pulse at the end of each frame's last stop bit
//  tx        out  1  serial line; idles high
// BEHAVIOUR
//  Reset (reset=0): tx=1, tx_ready=1, busy=0, tx_done=0, FSM=IDLE, holding empty, baud count=0.
//   Asynchronous: a frame cut by reset is abandoned and tx goes high immediately; no resume.
//  Accept: tx_start=1 and tx_ready=1 at edge k -> tx_byte captured, tx_ready=0 after edge k.
//   tx_start while tx_ready=0 is ignored; the holding byte is never overwritten.
//  Load: FSM in IDLE with holding full at edge k+1 -> byte moved to shift register,
//   holding freed (tx_ready=1 after k+1), FSM=START, tx=0 from edge k+1.
//   Latency from accept edge to start-bit edge: exactly 1 cycle.
//  FSM: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP(xSTOP_BITS) -> IDLE or START.
//   Each state/bit holds tx for exactly CLKS_PER_BIT cycles (baud counter 0..CLKS_PER_BIT-1).
//   DATA shifts right, bit index 0..7; PARITY bit = ^byte (even) or ~^byte (odd).
//   STOP drives tx=1.
//  Frame length: (1 + 8 + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles, with no gaps.
//  End of frame: tx_done=1 for the single cycle after the final stop-bit count expires.
//   If holding full at that edge -> go directly to START (back-to-back, zero idle bits).
//   Else -> IDLE, tx stays 1.
//  Simultaneous accept and end of frame at the same edge: the byte is captured into
//   holding this edge and loaded next edge; the line idles exactly 1 cycle (idle-high).
//  busy = (FSM != IDLE) | holding_full; registered outputs only, no combinational path
//   from tx_start to tx.
//  Baud counter width = $clog2(CLKS_PER_BIT); CLKS_PER_BIT < 2 is illegal (elaboration error).
// STRUCTURE
//  Shared include uart_defs.vh holds:
//   - FSM state encodings (IDLE, START, DATA, PARITY, STOP), also used by the receiver;
//   - default CLK_FREQ/BAUD values and the CLKS_PER_BIT derivation.
//  One sub-module uart_baud_gen: counter with clear, emits bit_tick when the count reaches
//   CLKS_PER_BIT-1; cleared on load so each frame starts phase-aligned.
//  Top FSM, holding register, shift register and parity logic live in uart_transmisor.
// TESTING
//  All benches: CLKS_PER_BIT=16; the bench samples tx mid-bit and checks every level.
//  1 Reset then idle 100 cycles -> tx=1, tx_ready=1, busy=0, tx_done never pulses.
//  2 Send 8'hA5, PARITY=0 -> line 0,1,0,1,0,0,1,0,1,1; 160 cycles;
//    tx_done pulses once at cycle 160 after start.
//  3 Send 8'h3C, then 8'hC3 while the first frame shifts -> both accepted, frames adjacent
//    with no idle bit between them, two tx_done pulses 160 cycles apart.
//  4 Third tx_start while holding full -> ignored; only two frames appear; tx_ready=0
//    until the second byte loads.
//  5 PARITY=1, byte 8'h07 -> parity bit 1; PARITY=2 -> 0; STOP_BITS=2 -> frame 192 cycles.
//  6 reset=0 mid-DATA (bit 4 of 8'hFF) -> tx=1 the same cycle; after release, 8'h00 sends
//    cleanly with correct timing.
//  Cross-check: loop tx into the team's UART receiver; 256 random bytes received identically.

Source files
------------

// File: rtl/uart_transmisor_pkg.sv
// Shared UART definitions: FSM state encodings, default line
// rates and helpers, also used by the UART receiver.
package uart_transmisor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int DEF_CLK_FREQ = 50_000_000;
   localparam int DEF_BAUD     = 9600;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   function automatic int clks_per_bit(
      input int clk_freq,
      input int baud
   );
      return clk_freq / baud;
   endfunction

   function automatic logic parity_bit(
      input logic [7:0] d,
      input int         mode
   );
      return (mode == PAR_ODD) ? ~^d : ^d;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: ticks on the last cycle of each bit,
// cleared on frame load so every frame starts phase-aligned.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic bit_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_cpb
         $error("uart_baud_gen: CLKS_PER_BIT must be >= 2");
      end
   endgenerate

   logic [CW-1:0] cnt;

   assign bit_tick = en & (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= bit_tick ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_transmisor.sv
// UART transmitter with one-byte holding register, LSB first,
// optional parity and one or two stop bits.
module uart_transmisor
   import uart_transmisor_pkg::*;
#(
   parameter int CLK_FREQ     = DEF_CLK_FREQ,
   parameter int BAUD         = DEF_BAUD,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_byte,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx
);

   localparam logic HAS_PAR = (PARITY != PAR_NONE);

   generate
      if (PARITY < 0 || PARITY > 2) begin : g_bad_par
         $error("uart_transmisor: PARITY must be 0, 1 or 2");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
         $error("uart_transmisor: STOP_BITS must be 1 or 2");
      end
   endgenerate

   uart_state_t state, state_n;

   logic       hold_full;
   logic [7:0] hold_byte;
   logic [7:0] shift, shift_n;
   logic       par, par_n;
   logic [2:0] bit_idx, bit_idx_n;
   logic       stop_idx, stop_idx_n;
   logic       stop_last;
   logic       load;
   logic       frame_end;
   logic       accept;
   logic       bit_tick;
   logic       tx_d;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .reset   (reset),
      .clear   (load),
      .en      (state != ST_IDLE),
      .bit_tick(bit_tick)
   );

   assign accept    = tx_start & ~hold_full;
   assign stop_last = (STOP_BITS == 1) || stop_idx;
   assign tx_ready  = ~hold_full;
   assign busy      = (state != ST_IDLE) | hold_full;

   // state register and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         hold_full <= 1'b0;
         hold_byte <= '0;
         shift     <= '0;
         par       <= 1'b0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         tx        <= 1'b1;
         tx_done   <= 1'b0;
      end else begin
         state    <= state_n;
         shift    <= shift_n;
         par      <= par_n;
         bit_idx  <= bit_idx_n;
         stop_idx <= stop_idx_n;
         tx       <= tx_d;
         tx_done  <= frame_end;
         if (accept) begin
            hold_full <= 1'b1;
            hold_byte <= tx_byte;
         end else if (load) begin
            hold_full <= 1'b0;
         end
      end
   end

   always_comb begin
      state_n   = state;
      load      = 1'b0;
      frame_end = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (hold_full) begin
               state_n = ST_START;
               load    = 1'b1;
            end
         end
         ST_START: begin
            if (bit_tick) state_n = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick && bit_idx == 3'd7)
               state_n = HAS_PAR ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (bit_tick) state_n = ST_STOP;
         end
         ST_STOP: begin
            // a waiting byte starts the next frame with no idle bit
            if (bit_tick && stop_last) begin
               frame_end = 1'b1;
               if (hold_full) begin
                  state_n = ST_START;
                  load    = 1'b1;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      shift_n    = shift;
      par_n      = par;
      bit_idx_n  = bit_idx;
      stop_idx_n = stop_idx;
      if (load) begin
         shift_n    = hold_byte;
         par_n      = parity_bit(hold_byte, PARITY);
         bit_idx_n  = '0;
         stop_idx_n = 1'b0;
      end else if (bit_tick) begin
         if (state == ST_DATA) begin
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
         end
         if (state == ST_STOP) stop_idx_n = ~stop_idx;
      end
   end

   // line level follows the state being entered
   always_comb begin
      tx_d = 1'b1;
      unique case (state_n)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_n[0];
         ST_PARITY: tx_d = par_n;
         default:   tx_d = 1'b1;
      endcase
   end

endmodule
